// File: rtl/relu_arbiter_pkg.sv
// Shared accelerator definitions: default activation width, output-stage FSM
// encoding and the lane-index width helper.
package relu_arbiter_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  // Lane index width; never collapses to zero bits.
  function automatic int lane_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/relu_arbiter_relu.sv
// ReLU activation: clamps a signed 2*WIDTH accumulator to zero and keeps the
// upper WIDTH bits of positive values.
module relu_arbiter_relu
  import relu_arbiter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [2*WIDTH-1:0] acc,
  output logic [WIDTH-1:0]   act
);

  assign act = ($signed(acc) <= 0) ? '0 : acc[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/relu_arbiter.sv
// Round-robin arbiter over N_LANES MAC lanes feeding a single registered
// ReLU output stage with frame marking and downstream backpressure.
module relu_arbiter
  import relu_arbiter_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int N_LANES   = 4,
  parameter int FRAME_LEN = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_LANES-1:0]            req_valid,
  input  logic [N_LANES*2*WIDTH-1:0]    req_data,
  output logic [N_LANES-1:0]            req_ready,
  output logic                          out_valid,
  output logic [WIDTH-1:0]              out_data,
  output logic [lane_w(N_LANES)-1:0]    out_lane,
  output logic                          out_last,
  input  logic                          out_ready
);

  localparam int LW = lane_w(N_LANES);
  localparam int DW = 2 * WIDTH;

  state_t              state, state_nxt;
  logic [LW-1:0]       ptr, ptr_nxt, grant_lane, offset;
  logic [LW:0]         lane_sum;
  logic [2*N_LANES-1:0] rotated;
  logic                found, grant, drain, can_accept, last_hit;
  logic [15:0]         frame_cnt;
  logic [DW-1:0]       sel_data;
  logic [WIDTH-1:0]    act;

  // Rotate so that lane ptr sits at bit 0; the first set bit is the winner.
  assign rotated = {req_valid, req_valid} >> ptr;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    found  = 1'b0;
    offset = '0;
    for (int k = 0; k < N_LANES; k++) begin
      if (!found && rotated[k]) begin
        found  = 1'b1;
        offset = LW'(k);
      end
    end
  end

  assign lane_sum   = {1'b0, ptr} + {1'b0, offset};
  assign grant_lane = (lane_sum >= (LW+1)'(N_LANES)) ? LW'(lane_sum - (LW+1)'(N_LANES))
                                                     : LW'(lane_sum);
  assign ptr_nxt    = (grant_lane == LW'(N_LANES - 1)) ? '0 : grant_lane + 1'b1;

  assign can_accept = (state == ST_EMPTY) || out_ready;
  assign grant      = found && can_accept && !rst;
  assign drain      = (state == ST_FULL) && out_ready;
  assign req_ready  = grant ? (N_LANES'(1) << grant_lane) : '0;
  assign out_valid  = (state == ST_FULL);
  assign last_hit   = (frame_cnt == 16'(FRAME_LEN - 1));

  always_comb begin
    sel_data = '0;
    for (int k = 0; k < N_LANES; k++) begin
      if (grant_lane == LW'(k)) sel_data = req_data[k*DW +: DW];
    end
  end

  relu_arbiter_relu #(.WIDTH(WIDTH)) u_relu (
    .acc (sel_data),
    .act (act)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_EMPTY: if (grant)          state_nxt = ST_FULL;
      ST_FULL:  if (drain && !grant) state_nxt = ST_EMPTY;
      default:                      state_nxt = ST_EMPTY;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_EMPTY;
      ptr       <= '0;
      frame_cnt <= '0;
      out_data  <= '0;
      out_lane  <= '0;
      out_last  <= 1'b0;
    end else begin
      state <= state_nxt;
      // Output fields only move on a grant, which keeps them stable under backpressure.
      if (grant) begin
        out_data  <= act;
        out_lane  <= grant_lane;
        out_last  <= last_hit;
        frame_cnt <= last_hit ? '0 : frame_cnt + 16'd1;
        ptr       <= ptr_nxt;
      end
    end
  end

endmodule

// File: tb/tb_relu_arbiter.sv
// Scoreboard bench for relu_arbiter: a behavioural model predicts grants and
// results; a separate monitor compares every downstream transfer.
module tb_relu_arbiter;

  localparam int WIDTH     = 8;
  localparam int N_LANES   = 4;
  localparam int FRAME_LEN = 3;

  logic                       clk = 1'b0;
  logic                       rst;
  logic [N_LANES-1:0]         req_valid;
  logic [N_LANES*2*WIDTH-1:0] req_data;
  logic [N_LANES-1:0]         req_ready;
  logic                       out_valid;
  logic [WIDTH-1:0]           out_data;
  logic [1:0]                 out_lane;
  logic                       out_last;
  logic                       out_ready;

  relu_arbiter #(.WIDTH(WIDTH), .N_LANES(N_LANES), .FRAME_LEN(FRAME_LEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_lane  (out_lane),
    .out_last  (out_last),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    int         lane;
    bit         last;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  int   m_ptr  = 0;
  int   m_cnt  = 0;
  bit   m_held = 0;

  task automatic check(input string name, input longint actual, input longint expected);
    n_cmp++;
    if (actual !== expected) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [7:0] relu_ref(input logic [15:0] raw);
    int v;
    v = int'($signed(raw));
    return (v <= 0) ? 8'd0 : 8'(v / 256);
  endfunction

  // Drive one cycle and advance the reference model across the coming edge.
  task automatic step(input logic [3:0] v, input logic [63:0] d, input logic ordy, input logic r);
    int         glane;
    logic [3:0] exp_ready;
    exp_t       e;
    @(negedge clk);
    req_valid = v;
    req_data  = d;
    out_ready = ordy;
    rst       = r;
    #1;
    glane     = -1;
    exp_ready = '0;
    if (!r && (!m_held || ordy)) begin
      for (int k = 0; k < N_LANES; k++) begin
        if (glane < 0 && v[(m_ptr + k) % N_LANES]) glane = (m_ptr + k) % N_LANES;
      end
    end
    if (glane >= 0) exp_ready[glane] = 1'b1;
    check("req_ready", req_ready, exp_ready);
    check("out_valid", out_valid, m_held);
    if (r) begin
      sb.delete();
      m_ptr  = 0;
      m_cnt  = 0;
      m_held = 0;
    end else if (glane >= 0) begin
      e.data = relu_ref(d[glane*16 +: 16]);
      e.lane = glane;
      m_cnt++;
      e.last = (m_cnt == FRAME_LEN);
      if (e.last) m_cnt = 0;
      sb.push_back(e);
      m_ptr  = (glane + 1) % N_LANES;
      m_held = 1;
    end else if (m_held && ordy) begin
      m_held = 0;
    end
  endtask

  function automatic logic [63:0] rand_data();
    return {$urandom, $urandom};
  endfunction

  // Monitor: compares drained outputs and checks stability while stalled.
  initial begin
    bit         hold = 0;
    logic [7:0] h_data;
    logic [1:0] h_lane;
    logic       h_last;
    exp_t       e;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        hold = 0;
      end else begin
        if (hold) begin
          check("hold_data", out_data, h_data);
          check("hold_lane", out_lane, h_lane);
          check("hold_last", out_last, h_last);
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            check("sb_underflow", 1, 0);
          end else begin
            e = sb.pop_front();
            check("out_data", out_data, e.data);
            check("out_lane", out_lane, e.lane);
            check("out_last", out_last, e.last);
          end
        end
        hold   = out_valid && !out_ready;
        h_data = out_data;
        h_lane = out_lane;
        h_last = out_last;
      end
    end
  end

  initial begin
    logic [15:0] corner[3];
    corner[0] = 16'hFF00;
    corner[1] = 16'h00FF;
    corner[2] = 16'h7FFF;
    rst = 1'b1; req_valid = '0; req_data = '0; out_ready = 1'b0;

    step(4'b0000, 64'h0, 1'b0, 1'b1);
    step(4'b0000, 64'h0, 1'b0, 1'b1);
    step(4'b0000, 64'h0, 1'b1, 1'b0);
    check("rst_out_data", out_data, 0);
    check("rst_out_lane", out_lane, 0);
    check("rst_out_last", out_last, 0);

    // Single lane, then sign/small-value corners.
    step(4'b0001, 64'h0300, 1'b1, 1'b0);
    step(4'b0000, 64'h0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(4'b0001, {48'h0, corner[i]}, 1'b1, 1'b0);
    step(4'b0000, 64'h0, 1'b1, 1'b0);

    // Fairness from a fresh pointer.
    step(4'b0000, 64'h0, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) step(4'b1111, rand_data(), 1'b1, 1'b0);

    // Backpressure with every lane requesting.
    for (int i = 0; i < 5; i++) step(4'b1111, rand_data(), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(4'b1111, rand_data(), 1'b1, 1'b0);
    step(4'b0000, 64'h0, 1'b1, 1'b0);

    // Framing: seven transfers, last on the 3rd and 6th.
    step(4'b0000, 64'h0, 1'b1, 1'b1);
    for (int i = 0; i < 7; i++) step(4'($urandom_range(1, 15)), rand_data(), 1'b1, 1'b0);
    step(4'b0000, 64'h0, 1'b1, 1'b0);

    // Mid-stream reset while an output from lane 2 is held.
    step(4'b0100, rand_data(), 1'b0, 1'b0);
    step(4'b1111, rand_data(), 1'b0, 1'b1);
    step(4'b1111, rand_data(), 1'b1, 1'b0);
    step(4'b0000, 64'h0, 1'b1, 1'b0);

    for (int i = 0; i < 3000; i++)
      step(4'($urandom), rand_data(), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 199) == 0));

    for (int i = 0; i < 4; i++) step(4'b0000, 64'h0, 1'b1, 1'b0);
    check("sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/relu_arbiter.md
RELU_ARBITER -- requirements
Module: relu_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, activation output width; inputs are 2*WIDTH-bit signed accumulator values.
REQ-002 SHALL have parameter N_LANES, default 4, number of requesting MAC lanes (2..16).
REQ-003 SHALL have parameter FRAME_LEN, default 16, outputs per frame (1..65535).
REQ-004 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port req_valid, input, N_LANES, per-lane request valid.
REQ-007 SHALL have port req_data, input, N_LANES*2*WIDTH, per-lane signed accumulator; lane i occupies bits [i*2*WIDTH +: 2*WIDTH].
REQ-008 SHALL have port req_ready, output, N_LANES, per-lane grant/accept strobe.
REQ-009 SHALL have port out_valid, output, 1, activation result valid.
REQ-010 SHALL have port out_data, output, WIDTH, activation result.
REQ-011 SHALL have port out_lane, output, clog2(N_LANES), source lane of out_data.
REQ-012 SHALL have port out_last, output, 1, marks the final output of a frame.
REQ-013 SHALL have port out_ready, input, 1, downstream accept.

Function
REQ-014 SHALL perform a lane transfer when req_valid[i] and req_ready[i] are both high on a rising clk edge; downstream transfer when out_valid and out_ready are both high.
REQ-015 SHALL assert at most one req_ready bit per cycle, only to a lane with req_valid high, and only when the output register is empty or is being drained in the same cycle.
REQ-016 SHALL choose the granted lane round-robin: search starts at lane ptr, ptr updates to (granted+1) mod N_LANES after each transfer, and is unchanged when no transfer occurs.
REQ-017 SHALL compute the result as 0 when the input is <= 0 (signed), otherwise input bits [2*WIDTH-1:WIDTH]; positive inputs below 2^WIDTH yield 0.
REQ-018 SHALL register the result, lane index and last flag, with out_valid asserting the cycle after the lane transfer (latency 1).
REQ-019 SHALL hold out_data, out_lane and out_last stable while out_valid is high and out_ready is low.
REQ-020 SHALL sustain one transfer per cycle when out_ready stays high and some lane is valid.
REQ-021 SHALL count accepted lane transfers in a frame counter, set out_last on the FRAME_LEN-th, and wrap the counter to 0 on that transfer.
REQ-022 SHALL use a two-state FSM: EMPTY (no valid output), FULL (output held); EMPTY->FULL on a grant; FULL->EMPTY on a drain without a grant; FULL->FULL on a simultaneous drain and grant.
REQ-023 SHALL not depend on out_ready for req_data sampling; req_ready may depend combinationally on req_valid and out_ready.

Reset
REQ-024 SHALL, on rst high at a clk edge, clear out_valid, out_data, out_lane, out_last, the frame counter and ptr to 0, and force the FSM to EMPTY.
REQ-025 SHALL hold req_ready at 0 during the reset cycle; an output in flight when reset asserts is discarded.

Structure
REQ-026 SHALL take WIDTH defaults, the FSM state encoding and the lane-index width function from the shared accelerator package.
REQ-027 SHALL instantiate the existing ReLu activation module as its single sub-module on the arbitrated data path.

Verification
REQ-028 SHALL cover a single lane: lane 0 sends 0x0300 (WIDTH=8) -> next cycle out_valid=1, out_data=0x03, out_lane=0.
REQ-029 SHALL cover negative and small positive inputs: 0xFF00 -> out_data=0x00; 0x00FF -> out_data=0x00; 0x7FFF -> out_data=0x7F.
REQ-030 SHALL cover fairness: all 4 lanes valid continuously with out_ready=1 -> out_lane sequence 0,1,2,3,0,... with one output per cycle.
REQ-031 SHALL cover backpressure: out_ready=0 for 5 cycles with an output held -> out_data and out_lane are stable, req_ready=0, and there is no loss or duplication after release.
REQ-032 SHALL cover framing: FRAME_LEN=3 and 7 transfers -> out_last=1 on outputs 3 and 6 only.
REQ-033 SHALL cover mid-stream reset: rst for 1 cycle while FULL -> out_valid=0 next cycle, and the next grant goes to lane 0 with the frame count restarted.
